ro_meas_ctrl: RTL and testbench

RO_MEAS_CTRL -- requirements
Module: ro_meas_ctrl

---
 rtl/ro_meas_pkg.sv | 22 ++
 rtl/ro_sync_edge.sv | 29 ++
 rtl/ro_meas_ctrl.sv | 143 ++++++++++++++
 tb/tb_ro_meas_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_meas_pkg.sv
// Shared types and constants for the ring-oscillator measurement controller.
package ro_meas_pkg;

  // Measurement sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CONFIG = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } meas_state_e;

  // Cycles spent with the oscillator off so edges still inside the synchronizer get counted
  localparam int DRAIN_CYC = 3;

  // Challenge field positions: [2:0] path selects, [5:3] bypass controls
  localparam int CHAL_SEL_LSB = 0;
  localparam int CHAL_SEL_MSB = 2;
  localparam int CHAL_BX_LSB  = 3;
  localparam int CHAL_BX_MSB  = 5;

endpackage

// File: rtl/ro_sync_edge.sv
// Two-flop synchronizer for the free-running oscillator output, followed by a
// rising-edge detector producing a single-cycle pulse per detected 0->1 transition.
module ro_sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_pulse
);

  logic r_meta;
  logic r_sync;
  logic r_sync_d;

  // Synchronizer chain plus one delayed copy for edge detection
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_meta   <= i_async;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
    end
  end

  assign o_pulse = r_sync & ~r_sync_d;

endmodule

// File: rtl/ro_meas_ctrl.sv
// Ring-oscillator measurement controller: latches a challenge, settles the
// oscillator configuration, enables it for a fixed window, counts synchronized
// rising edges (saturating) and hands the count over with a valid/ready handshake.
// SETTLE_CYC and WINDOW_CYC must both be at least 1.
module ro_meas_ctrl
  import ro_meas_pkg::*;
#(
  parameter int SETTLE_CYC = 4,
  parameter int WINDOW_CYC = 1000,
  parameter int CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [5:0]       i_chal,
  input  logic             i_ro_out,
  output logic [2:0]       o_sel,
  output logic [2:0]       o_bx,
  output logic             o_ro_en,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_count,
  output logic             o_count_valid,
  input  logic             i_count_ready
);

  // One shared down-counter times every timed phase; size it for the longest one
  localparam int LONGEST = (WINDOW_CYC > SETTLE_CYC) ? WINDOW_CYC : SETTLE_CYC;
  localparam int SPAN    = (LONGEST > DRAIN_CYC) ? LONGEST : DRAIN_CYC;
  localparam int TIMER_W = $clog2(SPAN + 1);

  meas_state_e        r_state;
  logic [TIMER_W-1:0] r_timer;
  logic               r_start_pend;
  logic [2:0]         r_sel;
  logic [2:0]         r_bx;
  logic               r_ro_en;
  logic               r_busy;
  logic [CNT_W-1:0]   r_count;
  logic               r_count_valid;

  logic               w_edge;
  logic               w_timer_done;
  logic               w_counting;

  ro_sync_edge u_sync_edge (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_ro_out),
    .o_pulse (w_edge)
  );

  assign w_timer_done = (r_timer == '0);
  assign w_counting   = (r_state == ST_RUN) || (r_state == ST_DRAIN);

  // Sequencer with registered outputs and saturating edge counter.
  // An accepted START spends one cycle latching the challenge before CONFIG
  // begins; BUSY is already raised in that cycle so a second START is refused.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_timer       <= '0;
      r_start_pend  <= 1'b0;
      r_sel         <= 3'b000;
      r_bx          <= 3'b000;
      r_ro_en       <= 1'b0;
      r_busy        <= 1'b0;
      r_count       <= '0;
      r_count_valid <= 1'b0;
    end else begin
      if (w_counting && w_edge && (r_count != {CNT_W{1'b1}})) begin
        r_count <= r_count + CNT_W'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (r_start_pend) begin
            r_start_pend <= 1'b0;
            r_timer      <= TIMER_W'(SETTLE_CYC - 1);
            r_state      <= ST_CONFIG;
          end else if (i_start) begin
            r_sel        <= i_chal[CHAL_SEL_MSB:CHAL_SEL_LSB];
            r_bx         <= i_chal[CHAL_BX_MSB:CHAL_BX_LSB];
            r_count      <= '0;
            r_start_pend <= 1'b1;
            r_busy       <= 1'b1;
          end
        end

        ST_CONFIG: begin
          if (w_timer_done) begin
            r_timer <= TIMER_W'(WINDOW_CYC - 1);
            r_ro_en <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_timer <= r_timer - TIMER_W'(1);
          end
        end

        ST_RUN: begin
          if (w_timer_done) begin
            r_timer <= TIMER_W'(DRAIN_CYC - 1);
            r_ro_en <= 1'b0;
            r_state <= ST_DRAIN;
          end else begin
            r_timer <= r_timer - TIMER_W'(1);
          end
        end

        ST_DRAIN: begin
          if (w_timer_done) begin
            r_count_valid <= 1'b1;
            r_state       <= ST_DONE;
          end else begin
            r_timer <= r_timer - TIMER_W'(1);
          end
        end

        ST_DONE: begin
          if (i_count_ready) begin
            r_count_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_state       <= ST_IDLE;
          end
        end

        default: begin
          r_ro_en       <= 1'b0;
          r_busy        <= 1'b0;
          r_count_valid <= 1'b0;
          r_state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_sel         = r_sel;
  assign o_bx          = r_bx;
  assign o_ro_en       = r_ro_en;
  assign o_busy        = r_busy;
  assign o_count       = r_count;
  assign o_count_valid = r_count_valid;

endmodule

// File: tb/tb_ro_meas_ctrl.sv
// Directed bench for ro_meas_ctrl: basic measurement, backpressure, busy/ignore,
// idle oscillator, reset mid-RUN with immediate restart, and counter saturation.
module tb_ro_meas_ctrl;

  localparam int S   = 4;
  localparam int W   = 100;
  localparam int LAT = S + W + 4;

  logic       clk = 1'b0;
  logic       rst_n;

  // Main instance (16-bit counter)
  logic       start1, ro1, ready1;
  logic [5:0] chal1;
  logic [2:0] sel1, bx1;
  logic       ro_en1, busy1, valid1;
  logic [15:0] count1;

  // Saturation instance (4-bit counter)
  logic       start2, ro2, ready2;
  logic [5:0] chal2;
  logic [2:0] sel2, bx2;
  logic       ro_en2, busy2, valid2;
  logic [3:0] count2;

  // Oscillator model control: hold mode pins RO_OUT at a constant level
  logic       ro1_hold;
  logic       ro1_level;

  int checks = 0;
  int errors = 0;
  int lat, en_cyc, vcnt;
  logic [15:0] cnt_snap;

  always #5 clk = ~clk;

  ro_meas_ctrl #(.SETTLE_CYC(S), .WINDOW_CYC(W), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_chal(chal1),
    .i_ro_out(ro1), .o_sel(sel1), .o_bx(bx1), .o_ro_en(ro_en1),
    .o_busy(busy1), .o_count(count1), .o_count_valid(valid1),
    .i_count_ready(ready1)
  );

  ro_meas_ctrl #(.SETTLE_CYC(S), .WINDOW_CYC(W), .CNT_W(4)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .i_chal(chal2),
    .i_ro_out(ro2), .o_sel(sel2), .o_bx(bx2), .o_ro_en(ro_en2),
    .o_busy(busy2), .o_count(count2), .o_count_valid(valid2),
    .i_count_ready(ready2)
  );

  // 40 ns oscillator that runs only while enabled
  initial begin
    ro1 = 1'b0;
    forever begin
      #20;
      if (ro1_hold)    ro1 = ro1_level;
      else if (ro_en1) ro1 = ~ro1;
      else             ro1 = 1'b0;
    end
  end

  // 20 ns oscillator for the saturation instance
  initial begin
    ro2 = 1'b0;
    forever begin
      #10;
      if (ro_en2) ro2 = ~ro2;
      else        ro2 = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulse START for one sampling edge on the main instance
  task automatic issue1(input logic [5:0] chal);
    @(negedge clk);
    chal1  = chal;
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
  endtask

  // Wait (bounded) for COUNT_VALID, counting RO_EN-high cycles; optionally
  // poke START/CHAL/READY mid-RUN and confirm the latched challenge holds
  task automatic wait1(input logic [5:0] chal, input bit poke, output int l, output int en);
    l  = 0;
    en = 0;
    for (int n = 1; n <= LAT + 50; n++) begin
      @(posedge clk);
      #1;
      if (ro_en1) en++;
      if (poke && n == S + 30) begin
        start1 = 1'b1;
        chal1  = ~chal;
        ready1 = 1'b1;
      end
      if (poke && n == S + 31) begin
        start1 = 1'b0;
        ready1 = 1'b0;
        check("busy_sel_hold", {29'd0, sel1}, {29'd0, chal[2:0]});
        check("busy_bx_hold", {29'd0, bx1}, {29'd0, chal[5:3]});
        check("busy_high_in_run", {31'd0, busy1}, 32'd1);
      end
      if (valid1) begin
        l = n;
        break;
      end
    end
  endtask

  // Single-cycle READY; DUT must be back in IDLE right after
  task automatic hs1(input string tag);
    @(negedge clk);
    ready1 = 1'b1;
    @(posedge clk);
    #1 ready1 = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, valid1}, 32'd0);
    check({tag, "_idle"}, {31'd0, busy1}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start1 = 1'b0; ready1 = 1'b0; chal1 = 6'd0;
    start2 = 1'b0; ready2 = 1'b0; chal2 = 6'd0;
    ro1_hold = 1'b0; ro1_level = 1'b0;

    // Reset state
    #1;
    check("rst_ro_en", {31'd0, ro_en1}, 32'd0);
    check("rst_sel", {29'd0, sel1}, 32'd0);
    check("rst_bx", {29'd0, bx1}, 32'd0);
    check("rst_count", {16'd0, count1}, 32'd0);
    check("rst_valid", {31'd0, valid1}, 32'd0);
    check("rst_busy", {31'd0, busy1}, 32'd0);
    check("rst_sat_valid", {31'd0, valid2}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic measurement
    issue1(6'b101_011);
    check("basic_busy", {31'd0, busy1}, 32'd1);
    wait1(6'b101_011, 1'b0, lat, en_cyc);
    check("basic_latency", lat, LAT);
    check("basic_ro_en_cycles", en_cyc, W);
    check("basic_sel", {29'd0, sel1}, 32'd3);
    check("basic_bx", {29'd0, bx1}, 32'd5);
    check("basic_count_range", {31'd0, (count1 >= 16'd24 && count1 <= 16'd26)}, 32'd1);
    $display("txn basic: latency=%0d ro_en_cycles=%0d count=%0d", lat, en_cyc, count1);

    // Backpressure: READY low for 10 cycles in DONE
    cnt_snap = count1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid_held", {31'd0, valid1}, 32'd1);
      check("bp_count_stable", {16'd0, count1}, {16'd0, cnt_snap});
    end
    hs1("bp");
    $display("txn backpressure: count=%0d", count1);
    @(posedge clk);
    #1;
    check("idle_sel_persist", {29'd0, sel1}, 32'd3);
    check("idle_bx_persist", {29'd0, bx1}, 32'd5);
    check("idle_count_retained", {16'd0, count1}, {16'd0, cnt_snap});

    // Busy/ignore: START and CHAL changes mid-RUN
    issue1(6'b010_110);
    wait1(6'b010_110, 1'b1, lat, en_cyc);
    check("busy_latency", lat, LAT);
    check("busy_final_sel", {29'd0, sel1}, 32'd6);
    check("busy_final_bx", {29'd0, bx1}, 32'd2);
    hs1("busy");
    vcnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (valid1 || busy1) vcnt++;
    end
    check("busy_single_result", vcnt, 0);
    $display("txn busy_ignore: latency=%0d count=%0d", lat, count1);

    // Idle oscillator: RO_OUT pinned high well before START
    ro1_hold = 1'b1;
    ro1_level = 1'b1;
    repeat (10) @(posedge clk);
    issue1(6'b000_111);
    wait1(6'b000_111, 1'b0, lat, en_cyc);
    check("idle_ro_latency", lat, LAT);
    check("idle_ro_count", {16'd0, count1}, 32'd0);
    hs1("idle_ro");
    $display("txn idle_ro: latency=%0d count=%0d", lat, count1);
    ro1_hold = 1'b0;
    repeat (5) @(posedge clk);

    // Reset mid-RUN at RUN cycle 50, then START on the first edge after release
    issue1(6'b111_001);
    for (int n = 0; n < 20 && !ro_en1; n++) begin
      @(posedge clk);
      #1;
    end
    check("rst_run_entered", {31'd0, ro_en1}, 32'd1);
    repeat (49) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ro_en", {31'd0, ro_en1}, 32'd0);
    check("midrst_count", {16'd0, count1}, 32'd0);
    check("midrst_valid", {31'd0, valid1}, 32'd0);
    check("midrst_busy", {31'd0, busy1}, 32'd0);
    check("midrst_sel", {29'd0, sel1}, 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    chal1  = 6'b100_010;
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    check("post_rst_start_taken", {31'd0, busy1}, 32'd1);
    wait1(6'b100_010, 1'b0, lat, en_cyc);
    check("post_rst_latency", lat, LAT);
    check("post_rst_sel", {29'd0, sel1}, 32'd2);
    check("post_rst_bx", {29'd0, bx1}, 32'd4);
    check("post_rst_count_range", {31'd0, (count1 >= 16'd24 && count1 <= 16'd26)}, 32'd1);
    hs1("post_rst");
    $display("txn reset_mid_run: latency=%0d count=%0d", lat, count1);

    // Saturation: 4-bit counter, 20 ns oscillator (~50 edges)
    @(negedge clk);
    chal2  = 6'b001_100;
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    lat = 0;
    for (int n = 1; n <= LAT + 50; n++) begin
      @(posedge clk);
      #1;
      if (valid2) begin
        lat = n;
        break;
      end
    end
    check("sat_latency", lat, LAT);
    check("sat_count", {28'd0, count2}, 32'd15);
    $display("txn saturation: latency=%0d count=%0d", lat, count2);
    @(negedge clk);
    ready2 = 1'b1;
    @(posedge clk);
    #1 ready2 = 1'b0;
    check("sat_valid_drop", {31'd0, valid2}, 32'd0);
    check("sat_count_retained", {28'd0, count2}, 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
